// File: rtl/operand_fetch.sv
// Register-read stage: drives register file read addresses, bypasses writeback, tracks
// pending writes in a scoreboard and captures operands into a valid/ready register.
// Optional stall counter output enabled by defining OPFETCH_PERF_EN.
module operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [$clog2(NREG)-1:0]  id_rs1_addr,
  input  logic [$clog2(NREG)-1:0]  id_rs2_addr,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [$clog2(NREG)-1:0]  id_rd_addr,
  input  logic                     id_rd_wen,
  output logic [$clog2(NREG)-1:0]  rf_rs1_addr,
  output logic [$clog2(NREG)-1:0]  rf_rs2_addr,
  input  logic [XLEN-1:0]          rf_rs1_data,
  input  logic [XLEN-1:0]          rf_rs2_data,
  input  logic                     wb_reg_write,
  input  logic [$clog2(NREG)-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [XLEN-1:0]          ex_rs1_data,
  output logic [XLEN-1:0]          ex_rs2_data,
  output logic [$clog2(NREG)-1:0]  ex_rd_addr,
  output logic                     ex_rd_wen
`ifdef OPFETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(NREG);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            wb_eff;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            wb_hit_rd;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_rs1_addr = id_rs1_addr;
  assign rf_rs2_addr = id_rs2_addr;

  // Writes to x0 are architecturally dropped, so they neither bypass nor clear.
  assign wb_eff     = wb_reg_write && (wb_rd_addr != AW'(0));
  assign wb_hit_rs1 = wb_eff && (wb_rd_addr == id_rs1_addr);
  assign wb_hit_rs2 = wb_eff && (wb_rd_addr == id_rs2_addr);
  assign wb_hit_rd  = wb_eff && (wb_rd_addr == id_rd_addr);

  always_comb begin
    op1 = rf_rs1_data;
    op2 = rf_rs2_data;
    if (id_rs1_addr == AW'(0)) op1 = '0;
    else if (wb_hit_rs1)       op1 = wb_data;
    if (id_rs2_addr == AW'(0)) op2 = '0;
    else if (wb_hit_rs2)       op2 = wb_data;
  end

  // RAW on either source or WAW on the destination, unless the producer writes back now.
  always_comb begin
    hazard = 1'b0;
    if (id_uses_rs1 && (id_rs1_addr != AW'(0)) && pending[id_rs1_addr] && !wb_hit_rs1)
      hazard = 1'b1;
    if (id_uses_rs2 && (id_rs2_addr != AW'(0)) && pending[id_rs2_addr] && !wb_hit_rs2)
      hazard = 1'b1;
    if (id_rd_wen && (id_rd_addr != AW'(0)) && pending[id_rd_addr] && !wb_hit_rd)
      hazard = 1'b1;
  end

  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  // Clears are applied before the accept's set so that set wins on the same index.
  always_comb begin
    pending_nxt = pending;
    if (wb_eff)
      pending_nxt[wb_rd_addr] = 1'b0;
    if (flush && ex_valid && ex_rd_wen)
      pending_nxt[ex_rd_addr] = 1'b0;
    if (accept && id_rd_wen)
      pending_nxt[id_rd_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Operand register: data fields only change on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd_addr  <= '0;
      ex_rd_wen   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_rs1_data <= op1;
      ex_rs2_data <= op2;
      ex_rd_addr  <= id_rd_addr;
      ex_rd_wen   <= id_rd_wen;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef OPFETCH_PERF_EN
  // Saturating count of cycles in which decode is held back by a hazard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_stall_cnt <= '0;
    else if (id_valid && hazard && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table plus reset/stall sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, id_rd_wen;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
`ifdef OPFETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen)
`ifdef OPFETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] rf1, rf2;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl, exr;
    logic        e_rdy, e_v;
    logic [31:0] e_d1, e_d2;
    logic [4:0]  e_rd;
    logic        e_wen;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_rd_addr = v.rd; id_rd_wen = v.wen;
    rf_rs1_data = v.rf1; rf_rs2_data = v.rf2;
    wb_reg_write = v.wbw; wb_rd_addr = v.wbrd; wb_data = v.wbd;
    flush = v.fl; ex_ready = v.exr;
  endtask

  initial begin
    vec_t idle;
    idle = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0};
    //          vld rs1 rs2 u1 u2 rd wen rf1 rf2 wbw wbrd wbd fl exr | rdy v d1 d2 rd wen
    vecs[0]  = '{1,5,0,1,0,0,0,'h11,'h22,0,0,0,0,1,         1,1,'h11,0,0,0};
    vecs[1]  = '{1,1,2,1,1,7,1,'hA,'hB,0,0,0,0,1,           1,1,'hA,'hB,7,1};
    vecs[2]  = '{1,7,0,1,0,8,0,'h77,0,0,0,0,0,1,            0,0,'hA,'hB,7,1};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1,7,0,1,0,8,0,'h77,0,1,7,'hCAFE,0,1,       1,1,'hCAFE,0,8,0};
    vecs[6]  = '{1,7,0,1,0,0,0,'h99,0,0,0,0,0,1,            1,1,'h99,0,0,0};
    vecs[7]  = '{1,3,4,1,1,10,0,'h33,'h44,0,0,0,0,1,        1,1,'h33,'h44,10,0};
    vecs[8]  = '{1,1,2,1,1,11,0,'h55,'h66,0,0,0,0,0,        0,1,'h33,'h44,10,0};
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = vecs[8];
    vecs[12] = '{1,1,2,1,1,11,0,'h55,'h66,0,0,0,0,1,        1,1,'h55,'h66,11,0};
    vecs[13] = '{1,2,3,1,1,12,0,'h56,'h67,0,0,0,0,1,        1,1,'h56,'h67,12,0};
    vecs[14] = '{1,1,0,1,0,9,1,'h1,0,1,9,'h123,0,1,         1,1,'h1,0,9,1};
    vecs[15] = '{1,9,0,1,0,0,0,'h90,0,0,0,0,0,1,            0,0,'h1,0,9,1};
    vecs[16] = '{1,9,0,1,0,0,0,'h90,0,1,9,'h999,0,1,        1,1,'h999,0,0,0};
    vecs[17] = '{1,0,0,0,0,3,1,'h5,'h6,0,0,0,0,1,           1,1,0,0,3,1};
    vecs[18] = '{1,4,0,1,0,0,0,'h44,0,0,0,0,1,1,            0,0,0,0,3,1};
    vecs[19] = '{1,3,0,1,1,0,0,'h333,0,1,0,'hFFFF,0,1,      1,1,'h333,0,0,0};
    vecs[20] = '{1,0,0,1,1,0,0,'hDEAD,'hBEEF,1,0,'hFFFF,0,1,1,1,0,0,0,0};
    vecs[21] = '{1,0,0,0,0,5,1,0,0,0,0,0,0,1,               1,1,0,0,5,1};
    vecs[22] = '{1,0,0,0,0,5,1,0,0,0,0,0,0,1,               0,0,0,0,5,1};
    vecs[23] = '{1,0,0,0,0,5,1,0,0,1,5,'h55,0,1,            1,1,0,0,5,1};
    vecs[24] = '{1,1,12,1,1,0,0,'h10,'h1,1,12,'h777,0,1,    1,1,'h10,'h777,0,0};

    drive(idle);
    reset = 1'b0;
    #1;
    chk("reset ex_valid", 32'(ex_valid), 0);
    chk("reset ex_rs1_data", ex_rs1_data, 0);
    chk("reset ex_rd_wen", 32'(ex_rd_wen), 0);
`ifdef OPFETCH_PERF_EN
    chk("reset perf", perf_stall_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d id_ready", i), 32'(id_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d rf_rs1_addr", i), 32'(rf_rs1_addr), 32'(vecs[i].rs1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d ex_rs1_data", i), ex_rs1_data, vecs[i].e_d1);
      chk($sformatf("v%0d ex_rs2_data", i), ex_rs2_data, vecs[i].e_d2);
      chk($sformatf("v%0d ex_rd_addr", i), 32'(ex_rd_addr), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d ex_rd_wen", i), 32'(ex_rd_wen), 32'(vecs[i].e_wen));
    end

    // Stall on pending x5 with execute backpressured, then reset mid-cycle.
    @(negedge clk);
    drive('{1,5,0,1,0,0,0,'h50,0,0,0,0,0,0, 0,0,0,0,0,0});
    #1;
    chk("pre-reset stall id_ready", 32'(id_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 0);
    chk("async reset ex_rs1_data", ex_rs1_data, 0);
    chk("async reset ex_rs2_data", ex_rs2_data, 0);
    chk("async reset ex_rd_addr", 32'(ex_rd_addr), 0);
    chk("async reset ex_rd_wen", 32'(ex_rd_wen), 0);
    chk("async reset scoreboard clear", 32'(id_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("post-reset x5 not stalled", 32'(id_ready), 1);
    @(posedge clk);
    #1;
    chk("post-reset accept x5", ex_rs1_data, 32'h50);

    // Make x6 pending, then stall on it for five cycles.
    @(negedge clk);
    drive('{1,0,0,0,0,6,1,0,0,0,0,0,0,1, 0,0,0,0,0,0});
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive('{1,6,0,1,0,0,0,'h60,0,0,0,0,0,1, 0,0,0,0,0,0});
      #1;
      chk($sformatf("x6 stall cycle %0d", c), 32'(id_ready), 0);
      @(posedge clk);
    end
    #1;
    chk("stall drains ex_valid", 32'(ex_valid), 0);
`ifdef OPFETCH_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 5);
`endif
    @(negedge clk);
    drive(idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage between decode and execute. It is the reader counterpart of the register file's writeback port.
- Drives the register file read addresses and captures the operands into a valid/ready pipeline register.
- Bypasses same-cycle writeback data.
- Holds a per-register pending-write scoreboard and stalls decode on RAW/WAW hazards until the producing writeback arrives.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers; address width is clog2(NREG)=5; register 0 is hardwired zero

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-low
id_valid  input  1  decode has an instruction
id_ready  output  1  stage accepts instruction this cycle
id_rs1_addr  input  5  source 1 index
id_rs2_addr  input  5  source 2 index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_rd_addr  input  5  destination index
id_rd_wen  input  1  instruction writes rd
rf_rs1_addr  output  5  register file read address 1 (=id_rs1_addr, combinational)
rf_rs2_addr  output  5  register file read address 2 (=id_rs2_addr, combinational)
rf_rs1_data  input  XLEN  register file read data 1 (combinational read)
rf_rs2_data  input  XLEN  register file read data 2
wb_reg_write  input  1  writeback strobe (same signal driven to register file)
wb_rd_addr  input  5  writeback destination
wb_data  input  XLEN  writeback value
flush  input  1  kill held entry
ex_valid  output  1  operand register holds valid entry
ex_ready  input  1  execute consumes entry
ex_rs1_data  output  XLEN  captured operand 1
ex_rs2_data  output  XLEN  captured operand 2
ex_rd_addr  output  5  captured destination
ex_rd_wen  output  1  captured write enable

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While reset=0: ex_valid=0, ex_rs1_data=0, ex_rs2_data=0, ex_rd_addr=0, ex_rd_wen=0, all pending bits=0. Reset asserted mid-operation discards everything immediately.
- Writeback is effective when wb_reg_write=1 and wb_rd_addr!=0. wb_rd_addr=0 is ignored for both bypass and scoreboard.
- Operand select, per source:
  - addr==0 -> 0.
  - Else effective writeback to same addr this cycle -> wb_data (bypass).
  - Else rf data.
- Hazard is combinational:
  - (uses_rs1 && rs1!=0 && pending[rs1] && !wb_hit_rs1), or
  - the same for rs2, or
  - (id_rd_wen && rd!=0 && pending[rd] && !wb_hit_rd), i.e. WAW.
- id_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Accept = id_valid && id_ready. On accept, next edge:
  - ex_valid=1; operands, rd_addr and rd_wen are captured.
  - Capture latency is one cycle.
- If ex_valid && ex_ready && !accept: ex_valid->0 and the data fields hold.
- If ex_valid && !ex_ready: all ex_* outputs hold stable.
- Scoreboard, 32 bits:
  - An effective writeback clears pending[wb_rd_addr].
  - An accept with id_rd_wen && rd!=0 sets pending[rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
- Flush: at the next edge, ex_valid->0. If the held entry is valid with ex_rd_wen, its pending bit is cleared (set/clear priority as above). No accept occurs in a flush cycle.
- Writebacks arrive in order, at most one per cycle. A writeback with no pending bit set just clears, and that is harmless.

Optional Feature:
- Macro OPFETCH_PERF_EN.
- When defined: extra output perf_stall_cnt (32 bits). It is reset to 0 and increments by 1 each cycle with id_valid && hazard, saturating at 0xFFFFFFFF.
- When undefined: the port and counter are absent and there is no other change.

Test Plan:
- Reset release, id_valid=1, rs1=5, rs2=0, rf_rs1_data=0x11 -> next cycle ex_valid=1, ex_rs1_data=0x11, ex_rs2_data=0.
- Accept rd=7 wen=1, then next instruction uses rs1=7 with no writeback -> id_ready=0 for 3 cycles. Writeback rd=7 data=0xCAFE in cycle 4 -> accepted that cycle with ex_rs1_data=0xCAFE (bypass), and pending[7] is cleared.
- ex_ready=0 for 4 cycles with ex_valid=1 -> ex_* outputs hold stable and id_ready=0. Then ex_ready=1 with back-to-back id_valid -> one accept per cycle.
- Writeback rd=9 in the same cycle as an accept with rd=9 wen=1 (rd=9 not previously pending) -> pending[9]=1 afterwards, and a following read of x9 stalls.
- Flush with held entry rd=3 wen=1 -> ex_valid=0 next cycle, pending[3]=0, and a subsequent read of x3 is not stalled. Writeback to rd=0 with data 0xFFFF -> read of x0 returns 0.
- Assert reset mid-stall with pending bits set -> all outputs 0 and scoreboard clear immediately. With OPFETCH_PERF_EN, 5 hazard cycles -> perf_stall_cnt=5.
